// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Brief    : Shared definitions for the 3-bit Booth multiplier control unit:
//             state encoding and default operand width.
//  Revision : 1.0  initial release
// ============================================================================
package booth_pkg;

    // Default operand width; also the number of add/sub-and-shift iterations.
    localparam int N_DEFAULT = 3;

    // State encoding of the control FSM.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        INIT  = ST_INIT,
        LOAD  = ST_LOAD,
        EVAL  = ST_EVAL,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage : booth_pkg
`default_nettype wire

// File: rtl/uc_booth.sv
`default_nettype none
// ============================================================================
//  Module   : uc_booth
//  Brief    : Control unit of the Booth multiplier. Sequences datapath clear,
//             operand load, N evaluate/shift iterations and a fin/start
//             handshake. EVAL decodes the registered {q0,qsub1} pair into
//             add / subtract / no-op.
//  Revision : 1.0  initial release
// ============================================================================
module uc_booth
    import booth_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic start,
    input  logic q0,
    input  logic qsub1,
    output logic CargaA,
    output logic CargaQ,
    output logic CargaM,
    output logic desplaza,
    output logic resta,
    output logic fin,
    output logic reset_dp,   // active-low datapath clear
    output logic busy
);

    localparam int             CW         = $clog2(N + 1);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and completed-shift counter; reset abandons any operation at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; outputs depend on state only, except the
    // EVAL add/subtract choice which follows the registered datapath bits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        CargaA   = 1'b0;
        CargaQ   = 1'b0;
        CargaM   = 1'b0;
        desplaza = 1'b0;
        resta    = 1'b0;
        fin      = 1'b0;
        reset_dp = 1'b1;
        busy     = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                reset_dp = 1'b0;
                cnt_d    = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                CargaQ  = 1'b1;
                CargaM  = 1'b1;
                state_d = EVAL;
            end
            EVAL: begin
                case ({q0, qsub1})
                    2'b10: begin
                        CargaA = 1'b1;
                        resta  = 1'b1;
                    end
                    2'b01: begin
                        CargaA = 1'b1;
                    end
                    default: begin
                        CargaA = 1'b0;
                    end
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                desplaza = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == C_CNT_LAST) ? DONE : EVAL;
            end
            DONE: begin
                fin = 1'b1;
                // Holding start high parks here, so no retrigger.
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule : uc_booth
`default_nettype wire

// File: tb/tb_uc_booth.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uc_booth
//  Brief    : Self-checking bench for uc_booth. A behavioural Booth datapath
//             answers the controller's commands; a phase-based reference gives
//             the expected control outputs every cycle and the signed product
//             at completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uc_booth;

    localparam int N    = 3;
    localparam int LAT  = 2 * N + 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic q0, qsub1;
    logic CargaA, CargaQ, CargaM, desplaza, resta, fin, reset_dp, busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural datapath state
    logic [N:0]     A   = '0;
    logic [N-1:0]   Qr  = '0;
    logic [N-1:0]   Mr  = '0;
    logic           Qm1 = 1'b0;
    logic [N-1:0]   entrada_m = '0;
    logic [N-1:0]   entrada_q = '0;
    logic [2*N-1:0] exp_prod  = '0;

    // Reference phase: 0 idle, 1..LAT cycles after start is sampled
    int t       = 0;
    int n_shift = 0;
    int n_clr   = 0;

    uc_booth #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .q0       (q0),
        .qsub1    (qsub1),
        .CargaA   (CargaA),
        .CargaQ   (CargaQ),
        .CargaM   (CargaM),
        .desplaza (desplaza),
        .resta    (resta),
        .fin      (fin),
        .reset_dp (reset_dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign q0    = Qr[0];
    assign qsub1 = Qm1;

    wire [7:0] act = {CargaA, CargaQ, CargaM, desplaza, resta, fin, reset_dp, busy};

    // Datapath responding to the controller's commands
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            A <= '0; Qr <= '0; Mr <= '0; Qm1 <= 1'b0;
        end else if (!reset_dp) begin
            A <= '0; Qr <= '0; Mr <= '0; Qm1 <= 1'b0;
        end else if (CargaQ || CargaM) begin
            if (CargaQ) Qr <= entrada_q;
            if (CargaM) Mr <= entrada_m;
        end else if (CargaA) begin
            A <= resta ? (A - {Mr[N-1], Mr}) : (A + {Mr[N-1], Mr});
        end else if (desplaza) begin
            {A, Qr, Qm1} <= {A[N], A, Qr};
        end
    end

    // Reference sequencing: start only matters in idle and in the done phase
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t <= 0;
        end else if (t == 0) begin
            if (start) t <= 1;
        end else if (t < LAT) begin
            t <= t + 1;
        end else if (!start) begin
            t <= 0;
        end
    end

    function automatic logic [7:0] expect_ctl(int ph, logic a, logic b);
        if (ph == 0)            return 8'b0000_0010;
        if (ph == 1)            return 8'b0000_0001;
        if (ph == 2)            return 8'b0110_0011;
        if (ph == LAT)          return 8'b0000_0111;
        if (ph % 2 == 0)        return 8'b0001_0011;
        if ({a, b} == 2'b10)    return 8'b1000_1011;
        if ({a, b} == 2'b01)    return 8'b1000_0011;
        return 8'b0000_0011;
    endfunction

    // Per-cycle comparison of every control output, plus product in DONE
    always @(negedge clk) begin
        logic [7:0] e;
        e = expect_ctl(t, q0, qsub1);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL ctl phase=%0d q0q1=%b%b actual=%b expected=%b (Aa Qq Mm Sh Rs Fn Rd By)",
                     t, q0, qsub1, act, e);
        end
        if (t == LAT) begin
            checks++;
            if ({A[N-1:0], Qr} !== exp_prod) begin
                failures++;
                $display("FAIL product actual=%b expected=%b", {A[N-1:0], Qr}, exp_prod);
            end
        end
        if (t == 0) begin
            n_shift = 0;
            n_clr   = 0;
        end else begin
            if (desplaza)  n_shift++;
            if (!reset_dp) n_clr++;
        end
    end

    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input int hold,
                          input bit noise, input bit lit_en, input logic [2*N-1:0] lit);
        int cyc;
        bit seen;
        int sm, sq;
        sm = int'($signed(m));
        sq = int'($signed(q));
        @(negedge clk);
        entrada_m = m;
        entrada_q = q;
        exp_prod  = (2*N)'(sm * sq);
        start     = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (fin) seen = 1'b1;
            else     start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL fin_timeout actual=no_fin required=fin_by_cycle_%0d", LAT);
        end else begin
            if (cyc != 9) begin
                failures++;
                $display("FAIL latency actual=%0d required=9", cyc);
            end
            checks++;
            if (n_shift != N || n_clr != 1) begin
                failures++;
                $display("FAIL pulse_count shifts=%0d clears=%0d required=%0d/1", n_shift, n_clr, N);
            end
            if (lit_en) begin
                checks++;
                if ({A[N-1:0], Qr} !== lit) begin
                    failures++;
                    $display("FAIL literal_product actual=%b required=%b", {A[N-1:0], Qr}, lit);
                end
            end
        end
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL return_idle busy actual=%b required=0", busy);
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        #1;
        checks++;
        if (act !== 8'b0000_0010) begin
            failures++;
            $display("FAIL reset_state actual=%b required=00000010", act);
        end
        #13 reset = 1'b1;

        // Hand-computed products
        run_op(3'b011, 3'b010, 0, 1'b0, 1'b1, 6'b000110);   //  3 x  2 =  6
        run_op(3'b011, 3'b101, 0, 1'b0, 1'b1, 6'b110111);   //  3 x -3 = -9
        run_op(3'b100, 3'b100, 5, 1'b0, 1'b1, 6'b010000);   // -4 x -4 = 16, start held
        run_op(3'b101, 3'b000, 0, 1'b0, 1'b1, 6'b000000);   // Q = 0
        run_op(3'b011, 3'b011, 0, 1'b0, 1'b1, 6'b001001);   // second product after hold

        // Abort during the second SHIFT with an asynchronous reset
        @(negedge clk);
        entrada_m = 3'b010;
        entrada_q = 3'b011;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (t != 6 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (t != 6 || desplaza !== 1'b1) begin
            failures++;
            $display("FAIL reach_shift2 phase=%0d desplaza=%b required=6/1", t, desplaza);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (act !== 8'b0000_0010) begin
            failures++;
            $display("FAIL async_reset actual=%b required=00000010", act);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(3'b110, 3'b011, 1, 1'b0, 1'b1, 6'b111010);   // -2 x 3 = -6

        // Randomised operands, start noise while busy, random hold in DONE
        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 4)), 1'b1, 1'b0, 6'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uc_booth
`default_nettype wire

// File: doc/uc_booth.md
# uc_booth

Control unit for the 3-bit Booth multiplier. It sits directly upstream of the `camino_datos` datapath and drives its load, shift, add/subtract and finish controls. It reads back `salida_q[0]` and `qsub1` to choose each iteration's operation. It sequences clear, operand load, N add/sub-and-shift iterations and a completion handshake.

## Interface
- `N`, default 3: operand width, which is also the iteration count. The counter width is `$clog2(N+1)`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a multiplication. Level-sampled in IDLE.
- `q0`  in  1  datapath `salida_q[0]`.
- `qsub1`  in  1  datapath Q-1 bit.
- `CargaA`  out  1  load A from the adder.
- `CargaQ`  out  1  load Q from `entrada_q`.
- `CargaM`  out  1  load M from `entrada_m`.
- `desplaza`  out  1  arithmetic right shift of A:Q:Q-1.
- `resta`  out  1  adder subtracts (A-M) when 1, adds when 0.
- `fin`  out  1  product valid on `resultado`.
- `reset_dp`  out  1  active-low datapath clear. Top level ANDs it with `reset`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has 6 states: IDLE, INIT, LOAD, EVAL, SHIFT, DONE. A counter `cnt` counts completed shifts.
- IDLE
  - All outputs are 0 except `reset_dp`=1.
  - `start`=1 → INIT.
- INIT
  - `reset_dp`=0 for exactly one cycle, which clears A, Q, M and Q-1.
  - `cnt`←0.
  - → LOAD.
- LOAD
  - `CargaQ`=`CargaM`=1.
  - → EVAL.
- EVAL: `CargaA` and `resta` are Mealy outputs decoded from `{q0,qsub1}`.
  - 10 → `CargaA`=1, `resta`=1.
  - 01 → `CargaA`=1, `resta`=0.
  - 00 or 11 → `CargaA`=0, `resta`=0.
  - → SHIFT.
- SHIFT
  - `desplaza`=1, `cnt`←`cnt`+1.
  - If `cnt`==N-1 → DONE, else → EVAL.
- DONE
  - `fin`=1, `busy`=1.
  - Stays in DONE while `start`=1. `start`=0 → IDLE.
  - A `start` that stays high does not retrigger a multiplication.
- `resta` is 0 whenever `CargaA`=0. No output glitches between states, except the EVAL decode of `q0`/`qsub1`, which are registered datapath signals.
- Loads, shift and clear are mutually exclusive: at most one of `CargaA`, `CargaQ`|`CargaM`, `desplaza`, `!reset_dp` is active in any cycle.
- Arithmetic and width rules are owned by the datapath: A is N+1 bits, sign-extended M, and the product is the 2N-bit `{A[N-1:0],Q}`. This block only counts to N.

## Timing
- Reset (async, `reset`=0):
  - State=IDLE, `cnt`=0.
  - `CargaA`=`CargaQ`=`CargaM`=`desplaza`=`resta`=`fin`=`busy`=0, `reset_dp`=1.
  - Takes effect immediately, including mid-operation. The sequence is abandoned and the outputs go to these values without waiting for a clock edge.
- Latency, counting edges after the edge that samples `start`=1 in IDLE:
  - INIT is cycle 1, LOAD is cycle 2, and EVAL/SHIFT pairs fill cycles 3…2N+2.
  - `fin` rises at cycle 2N+3, which is cycle 9 for N=3.
- `q0` and `qsub1` are valid in EVAL because the preceding LOAD or SHIFT has updated them at the prior edge.
- `start` toggling during INIT…SHIFT is ignored.

## Structure
- Shared package `booth_pkg`: state encoding localparams (IDLE..DONE) and the default `N`.
- Two always blocks:
  - sequential: state and `cnt`, with async clear on `negedge reset`.
  - combinational: next-state and output decode.
- No sub-module needed. The iteration counter stays inline.
- Integration top `multiplicador_booth` instantiates `uc_booth` + `camino_datos` and gates the datapath reset with `reset & reset_dp`.

## Test plan
- Integrated with the datapath, 3 × 2: `start` pulse → `fin` at cycle 9, `resultado`=6'b000110, `busy` high in cycles 1-9.
- -3 × 3 (Q=3'b101, M=3'b011): EVAL cycles show `resta`=1 at iterations 1 and 3 (bit pairs 10) and `CargaA`=1, `resta`=0 at iteration 2 (pair 01); `resultado`=6'b110111 (-9).
- -4 × -4: `resultado`=6'b010000 (+16). Exactly 3 `desplaza` pulses and 1 `reset_dp` low cycle per operation.
- Q=0: no `CargaA` pulse in any EVAL, `resultado`=0, `fin` still at cycle 9.
- `start` held high through DONE for 5 cycles: `fin` stays 1 and there is no second INIT. `start`=0 → IDLE next edge, and a fresh `start` then gives a correct second product.
- `reset`=0 asserted during the second SHIFT: outputs immediately take their reset values, state=IDLE. After release, a new `start` completes normally in 9 cycles.
